simd_dot_unit: RTL
==================

SIMD_DOT_UNIT -- requirements
Module: simd_dot_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning operand and result width.
REQ-002 The module SHALL have parameter LANE_W, default 8, meaning lane width; legal values are 8 and 16.
REQ-003 The module SHALL have parameter TRANS_ID_BITS, default 4, meaning transaction-ID width.
REQ-004 The module SHALL have parameter SAT_EN, default 1; when 0, sat_i is ignored and results always wrap.
REQ-005 The module SHALL derive LANES = XLEN/LANE_W, which must be a power of two >= 2; illegal parameter sets are rejected at elaboration.
REQ-006 The module SHALL have port clk_i, input, 1 bit: clock.
REQ-007 The module SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The module SHALL have port valid_i, input, 1 bit: the operation is issued this cycle.
REQ-009 The module SHALL have port flush_i, input, 1 bit: pipeline flush.
REQ-010 The module SHALL have port sign_i, input, 2 bits: bit1 = operand A lanes signed, bit0 = operand B lanes signed.
REQ-011 The module SHALL have port acc_i, input, 1 bit: add operand_c_i to the dot product.
REQ-012 The module SHALL have port sat_i, input, 1 bit: saturate the final result to the signed XLEN range.
REQ-013 The module SHALL have ports operand_a_i, operand_b_i and operand_c_i, each input, XLEN bits: source operands.
REQ-014 The module SHALL have port trans_id_i, input, TRANS_ID_BITS bits: tag of the issued operation.
REQ-015 The module SHALL have port result_o, output, XLEN bits: result.
REQ-016 The module SHALL have port valid_o, output, 1 bit: result_o and trans_id_o are valid this cycle.
REQ-017 The module SHALL have port ready_o, output, 1 bit: ready to accept an operation.
REQ-018 The module SHALL have port trans_id_o, output, TRANS_ID_BITS bits: tag returned with the result.

Function
REQ-019 The module SHALL compute the sum over lanes i of A[i]*B[i], where each lane is extended as signed or unsigned per sign_i.
REQ-020 When acc_i=1, operand_c_i (signed) SHALL be added to the sum; when acc_i=0, zero SHALL be added.
REQ-021 Lane products SHALL be held at 2*LANE_W+1 bits.
REQ-022 The tree sum SHALL grow by one bit per level, with sign extension; no intermediate overflow is permitted.
REQ-023 The final add SHALL be performed at max(XLEN, tree width)+1 bits, signed.
REQ-024 When sat_i=0 or SAT_EN=0, result_o SHALL be the low XLEN bits of the final sum (wrap modulo 2^XLEN).
REQ-025 When sat_i=1 and SAT_EN=1, result_o SHALL be clamped to [-2^(XLEN-1), 2^(XLEN-1)-1].
REQ-026 The pipeline SHALL consist of: stage M (lane products registered), log2(LANES) adder-tree stages (one register per level), and stage F (accumulate/saturate registered).
REQ-027 Latency SHALL be 2+log2(LANES) cycles from the valid_i edge to valid_o; this is 4 cycles at the defaults.
REQ-028 Throughput SHALL be one operation per cycle.
REQ-029 ready_o SHALL be constant 1; the unit has no backpressure.
REQ-030 operand_c_i, acc_i, sat_i and trans_id_i SHALL travel alongside the data in every stage.
REQ-031 Each stage's valid flag SHALL be next = (previous-stage valid) AND NOT flush_i.
REQ-032 A stage whose next valid flag is 0 SHALL load zero data and a zero trans_id.
REQ-033 flush_i=1 at an edge SHALL clear every stage's valid flag, including a simultaneous valid_i.
REQ-034 Operations issued in the cycle after flush_i deasserts SHALL proceed normally.
REQ-035 valid_o SHALL be the stage F valid register; it is not combinationally gated.
REQ-036 result_o and trans_id_o SHALL be zero whenever valid_o=0.
REQ-037 Operation order SHALL be preserved; there is no reordering or merging.

Reset
REQ-038 rst_i=0 SHALL asynchronously clear all valid flags, data registers and trans_id registers to zero.
REQ-039 While in reset, valid_o SHALL be 0, result_o 0, trans_id_o 0, and ready_o 1.
REQ-040 Reset during operation SHALL discard all in-flight operations; none appears after release.
REQ-041 The first operation accepted after release SHALL appear at the nominal latency.

Verification
REQ-042 At defaults, sign_i=11, acc_i=0, A=0x01020304, B=0x01010101, trans_id_i=5 -> valid_o exactly 4 cycles later, result_o=0x0000000A, trans_id_o=5.
REQ-043 Operand A=0xFFFFFFFF and B=0xFFFFFFFF -> sign_i=10 gives 0xFFFFFC04 (-1020); sign_i=00 gives 0x0003F804 (260100); sign_i=11 gives 0x00000004.
REQ-044 sign_i=11, A=B=0x80808080, acc_i=1, C=0x7FFFFFFF -> sat_i=1 gives 0x7FFFFFFF; sat_i=0 gives 0x8000FFFF.
REQ-045 Issue ops with IDs 1,2,3 on cycles 0-2 with flush_i=1 on cycle 2, then ID 4 on cycle 3 -> IDs 1-3 never return valid_o; ID 4 returns on cycle 7 with valid_o=1.
REQ-046 Issue 8 back-to-back ops with IDs 0..7 and random operands -> 8 consecutive valid_o cycles, in order, each matching the reference model.
REQ-047 Pulse rst_i low for one cycle with 3 ops in flight -> valid_o drops to 0 immediately and stays 0 until the next issued op plus 4 cycles; at LANE_W=16 the latency is 3 cycles.

Source files
------------

// File: rtl/simd_dot_unit.sv
// simd_dot_unit: pipelined packed-SIMD dot product with optional
// signed accumulate and signed saturation of the final result.
module simd_dot_unit #(
    parameter int XLEN          = 32,
    parameter int LANE_W        = 8,
    parameter int TRANS_ID_BITS = 4,
    parameter int SAT_EN        = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic                     flush_i,
    input  logic [1:0]               sign_i,
    input  logic                     acc_i,
    input  logic                     sat_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [XLEN-1:0]          operand_c_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic [XLEN-1:0]          result_o,
    output logic                     valid_o,
    output logic                     ready_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
);
    localparam int LANES  = XLEN / LANE_W;
    localparam int LEVELS = $clog2(LANES);
    localparam int PW     = 2 * LANE_W + 1;
    localparam int TW     = PW + LEVELS;
    localparam int FW     = ((XLEN > TW) ? XLEN : TW) + 1;
    localparam int NS     = LEVELS + 1;

    localparam logic signed [FW-1:0] SMAX =
        {{(FW-XLEN+1){1'b0}}, {(XLEN-1){1'b1}}};
    localparam logic signed [FW-1:0] SMIN =
        {{(FW-XLEN+1){1'b1}}, {(XLEN-1){1'b0}}};

    if (LANE_W != 8 && LANE_W != 16) begin : g_bad_lane_w
        $error("simd_dot_unit: LANE_W must be 8 or 16");
    end
    if ((XLEN % LANE_W) != 0 || LANES < 2 ||
        (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
        $error("simd_dot_unit: XLEN/LANE_W must be a power of two >= 2");
    end

    // Index 0 is stage M, indices 1..LEVELS are the adder-tree levels.
    logic                     v_q   [NS];
    logic                     v_d   [NS];
    logic signed [TW-1:0]     sum_q [NS][LANES];
    logic signed [TW-1:0]     sum_d [NS][LANES];
    logic [XLEN-1:0]          c_q   [NS];
    logic [XLEN-1:0]          c_d   [NS];
    logic                     acc_q [NS];
    logic                     acc_d [NS];
    logic                     sat_q [NS];
    logic                     sat_d [NS];
    logic [TRANS_ID_BITS-1:0] id_q  [NS];
    logic [TRANS_ID_BITS-1:0] id_d  [NS];

    logic                     vf_q;
    logic                     vf_d;
    logic [XLEN-1:0]          res_q;
    logic [XLEN-1:0]          res_d;
    logic [TRANS_ID_BITS-1:0] idf_q;
    logic [TRANS_ID_BITS-1:0] idf_d;

    always_comb begin
        v_d[0]   = valid_i & ~flush_i;
        c_d[0]   = v_d[0] ? operand_c_i : '0;
        acc_d[0] = v_d[0] & acc_i;
        sat_d[0] = v_d[0] & sat_i;
        id_d[0]  = v_d[0] ? trans_id_i : '0;
        for (int s = 1; s < NS; s++) begin
            v_d[s]   = v_q[s-1] & ~flush_i;
            c_d[s]   = v_d[s] ? c_q[s-1] : '0;
            acc_d[s] = v_d[s] & acc_q[s-1];
            sat_d[s] = v_d[s] & sat_q[s-1];
            id_d[s]  = v_d[s] ? id_q[s-1] : '0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0]    a_l;
        logic [LANE_W-1:0]    b_l;
        logic signed [PW-1:0] a_x;
        logic signed [PW-1:0] b_x;
        logic signed [PW-1:0] p;
        assign a_l = operand_a_i[i*LANE_W +: LANE_W];
        assign b_l = operand_b_i[i*LANE_W +: LANE_W];
        assign a_x = {{(PW-LANE_W){sign_i[1] & a_l[LANE_W-1]}}, a_l};
        assign b_x = {{(PW-LANE_W){sign_i[0] & b_l[LANE_W-1]}}, b_l};
        // The exact product always fits in PW signed bits.
        assign p   = a_x * b_x;
        assign sum_d[0][i] = v_d[0] ? TW'(p) : '0;
    end

    for (genvar l = 1; l < NS; l++) begin : g_lvl
        for (genvar j = 0; j < LANES; j++) begin : g_node
            if (j < (LANES >> l)) begin : g_add
                assign sum_d[l][j] = v_d[l] ?
                    sum_q[l-1][2*j] + sum_q[l-1][2*j+1] : '0;
            end else begin : g_pad
                assign sum_d[l][j] = '0;
            end
        end
    end

    logic signed [FW-1:0] tree_x;
    logic signed [FW-1:0] c_x;
    logic signed [FW-1:0] fsum;

    assign tree_x = FW'(sum_q[LEVELS][0]);
    assign c_x    = acc_q[LEVELS] ? FW'($signed(c_q[LEVELS])) : '0;
    assign fsum   = tree_x + c_x;

    always_comb begin
        vf_d  = v_q[LEVELS] & ~flush_i;
        idf_d = vf_d ? id_q[LEVELS] : '0;
        res_d = fsum[XLEN-1:0];
        if (SAT_EN != 0 && sat_q[LEVELS]) begin
            if (fsum > SMAX) begin
                res_d = SMAX[XLEN-1:0];
            end else if (fsum < SMIN) begin
                res_d = SMIN[XLEN-1:0];
            end
        end
        if (!vf_d) begin
            res_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int s = 0; s < NS; s++) begin
                v_q[s]   <= 1'b0;
                c_q[s]   <= '0;
                acc_q[s] <= 1'b0;
                sat_q[s] <= 1'b0;
                id_q[s]  <= '0;
                for (int j = 0; j < LANES; j++) begin
                    sum_q[s][j] <= '0;
                end
            end
            vf_q  <= 1'b0;
            res_q <= '0;
            idf_q <= '0;
        end else begin
            for (int s = 0; s < NS; s++) begin
                v_q[s]   <= v_d[s];
                c_q[s]   <= c_d[s];
                acc_q[s] <= acc_d[s];
                sat_q[s] <= sat_d[s];
                id_q[s]  <= id_d[s];
                for (int j = 0; j < LANES; j++) begin
                    sum_q[s][j] <= sum_d[s][j];
                end
            end
            vf_q  <= vf_d;
            res_q <= res_d;
            idf_q <= idf_d;
        end
    end

    assign valid_o    = vf_q;
    assign result_o   = res_q;
    assign trans_id_o = idf_q;
    assign ready_o    = 1'b1;

endmodule
